// File: rtl/vec_dot_pkg.sv
// Shared types and helpers for the vector dot-product engine.
// Holds FSM state codes plus lane-mask and saturation-bound functions.
package vec_dot_pkg;

    localparam int EXT_W = 128;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic lane_en(input int lane, input int rem);
        return lane < rem;
    endfunction

    // Bounds are returned sign-extended to EXT_W so they compare directly.
    function automatic logic [EXT_W-1:0] sat_max(input logic sgn, input int w);
        return {EXT_W{1'b1}} >> (EXT_W - (sgn ? w - 1 : w));
    endfunction

    function automatic logic [EXT_W-1:0] sat_min(input logic sgn, input int w);
        return sgn ? ({EXT_W{1'b1}} << (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/vec_dot_if.sv
// Control, streaming-input and result bundle of the dot-product engine.
// The engine side uses the slave modport.
interface vec_dot_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 16
);
    logic                      start;
    logic [LEN_W-1:0]          vec_len;
    logic                      signed_mode;
    logic                      sat_mode;
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic                      overflow;
    logic [ACC_W-1:0]          result;

    modport master (
        output start, vec_len, signed_mode, sat_mode,
        output in_valid, in_a, in_b,
        input  in_ready, busy, done, error, overflow, result
    );

    modport slave (
        input  start, vec_len, signed_mode, sat_mode,
        input  in_valid, in_a, in_b,
        output in_ready, busy, done, error, overflow, result
    );
endinterface

// File: rtl/vec_dot_lane_mult.sv
// One lane multiplier with selectable signed/unsigned product.
// Operands are extended to full width so one multiplier serves both modes.
module vec_dot_lane_mult #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                sgn,
    output logic [2*DATA_W-1:0] p
);
    logic [2*DATA_W-1:0] ax;
    logic [2*DATA_W-1:0] bx;

    assign ax = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    assign bx = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    assign p  = ax * bx;
endmodule

// File: rtl/vec_dot_engine.sv
// Streaming multi-lane dot-product engine with a two-stage MAC pipeline,
// optional saturation and sticky overflow.
module vec_dot_engine
    import vec_dot_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int ACC_W  = 48,
    parameter int LEN_W  = 16
) (
    input logic     clk,
    input logic     rstn,
    vec_dot_if.slave bus
);
    localparam int PW = 2 * DATA_W;

    state_t           state;
    logic [LEN_W:0]   beats_left;
    logic [LEN_W:0]   beats_init;
    logic [LEN_W-1:0] elems_left;
    logic             sgn_q, sat_q, err_q, ovf_q;
    logic [ACC_W-1:0] acc, res_q;
    logic             s1_valid, s1_last, s2_last, s3_last;
    logic             accept, xfer, last_beat, pos_ovf, neg_ovf;
    logic [PW-1:0]    prod   [LANES];
    logic [PW-1:0]    prod_q [LANES];
    logic [EXT_W-1:0] term, acc_x, full, max_x, min_x;

    assign accept     = (state == ST_IDLE) && bus.start;
    assign xfer       = (state == ST_RUN) && bus.in_valid;
    assign last_beat  = beats_left == (LEN_W+1)'(1);
    assign beats_init = ({1'b0, bus.vec_len} + (LEN_W+1)'(LANES - 1))
                        / (LEN_W+1)'(LANES);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic              en;
        logic [DATA_W-1:0] a_m, b_m;
        assign en  = lane_en(i, int'(elems_left));
        assign a_m = en ? bus.in_a[i*DATA_W +: DATA_W] : '0;
        assign b_m = en ? bus.in_b[i*DATA_W +: DATA_W] : '0;
        vec_dot_lane_mult #(.DATA_W(DATA_W)) u_mult (
            .a   (a_m),
            .b   (b_m),
            .sgn (sgn_q),
            .p   (prod[i])
        );
    end

    always_comb begin
        term = '0;
        for (int i = 0; i < LANES; i++) begin
            term = term + (sgn_q ? {{(EXT_W-PW){prod_q[i][PW-1]}}, prod_q[i]}
                                 : {{(EXT_W-PW){1'b0}}, prod_q[i]});
        end
    end

    assign acc_x   = {{(EXT_W-ACC_W){sgn_q & acc[ACC_W-1]}}, acc};
    assign full    = acc_x + term;
    assign max_x   = sat_max(sgn_q, ACC_W);
    assign min_x   = sat_min(sgn_q, ACC_W);
    assign pos_ovf = $signed(full) > $signed(max_x);
    assign neg_ovf = $signed(full) < $signed(min_x);

    assign bus.in_ready = state == ST_RUN;
    assign bus.busy     = state != ST_IDLE;
    assign bus.done     = state == ST_DONE;
    assign bus.error    = (state == ST_DONE) && err_q;
    assign bus.overflow = ovf_q;
    assign bus.result   = res_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            elems_left <= '0;
            sgn_q      <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            res_q      <= '0;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.start) begin
                    sgn_q      <= bus.signed_mode;
                    sat_q      <= bus.sat_mode;
                    res_q      <= '0;
                    elems_left <= bus.vec_len;
                    beats_left <= beats_init;
                    err_q      <= bus.vec_len == '0;
                    state      <= (bus.vec_len == '0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: if (bus.in_valid) begin
                    beats_left <= beats_left - (LEN_W+1)'(1);
                    elems_left <= last_beat ? '0
                                            : elems_left - LEN_W'(LANES);
                    if (last_beat) state <= ST_DRAIN;
                end
                // s3_last marks the cycle after stage 2 took the last sum.
                ST_DRAIN: if (s3_last) begin
                    res_q <= acc;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
            s3_last  <= 1'b0;
            acc      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s1_valid <= xfer;
            s1_last  <= xfer && last_beat;
            s2_last  <= s1_last;
            s3_last  <= s2_last;
            if (accept) begin
                acc   <= '0;
                ovf_q <= 1'b0;
            end else if (s1_valid && !(sat_q && ovf_q)) begin
                if (pos_ovf || neg_ovf) begin
                    ovf_q <= 1'b1;
                    acc   <= !sat_q  ? full[ACC_W-1:0]  :
                             pos_ovf ? max_x[ACC_W-1:0] : min_x[ACC_W-1:0];
                end else begin
                    acc <= full[ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < LANES; i++) prod_q[i] <= prod[i];
        end
    end

endmodule

// File: tb/tb_vec_dot_engine.sv
// Bench for vec_dot_engine: a 48-bit and a 32-bit accumulator instance
// share one stimulus stream and are checked against a behavioural model.
module tb_vec_dot_engine;

    localparam int LANES = 2;
    localparam int DW    = 16;
    localparam int LW    = 16;

    typedef struct {
        int          cyc;
        logic [47:0] r48;
        logic        o48;
        logic [31:0] r32;
        logic        o32;
        logic        err;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0, sgn = 1'b0, sat = 1'b0, in_valid = 1'b0;
    logic [LW-1:0]       vec_len = '0;
    logic [LANES*DW-1:0] in_a = '0, in_b = '0;

    int   cyc = 0, checks = 0, errors = 0;
    exp_t q[$];
    exp_t cur;
    logic [15:0] ea[256], eb[256];
    logic [47:0] got48;
    logic [31:0] got32;
    logic        gov48, gov32, gerr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_dot_if #(.ACC_W(48)) if48 ();
    vec_dot_if #(.ACC_W(32)) if32 ();

    assign if48.start = start;       assign if32.start = start;
    assign if48.vec_len = vec_len;   assign if32.vec_len = vec_len;
    assign if48.signed_mode = sgn;   assign if32.signed_mode = sgn;
    assign if48.sat_mode = sat;      assign if32.sat_mode = sat;
    assign if48.in_valid = in_valid; assign if32.in_valid = in_valid;
    assign if48.in_a = in_a;         assign if32.in_a = in_a;
    assign if48.in_b = in_b;         assign if32.in_b = in_b;

    vec_dot_engine #(.ACC_W(48)) u48 (.clk(clk), .rstn(rstn), .bus(if48));
    vec_dot_engine #(.ACC_W(32)) u32 (.clk(clk), .rstn(rstn), .bus(if32));

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Dot product of ea/eb taken LANES elements per accumulate step.
    function automatic void model(input int len, input bit sg, input bit st,
                                  input int w, output logic [63:0] r,
                                  output logic ov);
        longint acc = 0, mx, mn, s, span;
        bit cl = 0;
        span = longint'(1) << w;
        mx = sg ? (span >>> 1) - 1 : span - 1;
        mn = sg ? -(span >>> 1) : 0;
        ov = 1'b0;
        for (int k = 0; k < len; k += LANES) begin
            s = 0;
            for (int i = 0; i < LANES; i++)
                if (k + i < len)
                    s += sg ? longint'($signed(ea[k+i])) * longint'($signed(eb[k+i]))
                            : longint'(ea[k+i]) * longint'(eb[k+i]);
            if (!cl) begin
                acc += s;
                if (acc > mx || acc < mn) begin
                    ov = 1'b1;
                    if (st) begin
                        acc = (acc > mx) ? mx : mn;
                        cl  = 1;
                    end else begin
                        acc = acc % span;
                        if (acc < 0) acc += span;
                        if (sg && acc > mx) acc -= span;
                    end
                end
            end
        end
        r = 64'(acc);
    endfunction

    task automatic prep(input int len, input bit sg, input bit st);
        logic [63:0] r;
        logic        o;
        model(len, sg, st, 48, r, o);
        cur.r48 = r[47:0];
        cur.o48 = o;
        model(len, sg, st, 32, r, o);
        cur.r32 = r[31:0];
        cur.o32 = o;
        cur.err = len == 0;
    endtask

    task automatic chk_cycle();
        bit ed = 0, ee = 0;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            ed = 1;
            ee = q[0].err;
        end
        chk("done48", 64'(if48.done), 64'(ed));
        chk("done32", 64'(if32.done), 64'(ed));
        chk("error48", 64'(if48.error), 64'(ee));
        chk("error32", 64'(if32.error), 64'(ee));
        if (ed) begin
            got48 = if48.result;
            got32 = if32.result;
            gov48 = if48.overflow;
            gov32 = if32.overflow;
            gerr  = if48.error;
            chk("result48", 64'(if48.result), 64'(q[0].r48));
            chk("result32", 64'(if32.result), 64'(q[0].r32));
            chk("overflow48", 64'(if48.overflow), 64'(q[0].o48));
            chk("overflow32", 64'(if32.overflow), 64'(q[0].o32));
            void'(q.pop_front());
        end
    endtask

    always @(negedge clk) if (rstn) chk_cycle();

    task automatic chk_idle(input string nm);
        chk({nm, "_ctl48"}, 64'({if48.in_ready, if48.busy, if48.done,
                                 if48.error, if48.overflow}), 64'(0));
        chk({nm, "_ctl32"}, 64'({if32.in_ready, if32.busy, if32.done,
                                 if32.error, if32.overflow}), 64'(0));
        chk({nm, "_res48"}, 64'(if48.result), 64'(0));
        chk({nm, "_res32"}, 64'(if32.result), 64'(0));
    endtask

    task automatic run(input int len, input bit sg, input bit st,
                       input bit gaps, input logic [15:0] fill,
                       input int abort_at, input bit poke);
        int nb, k, g, e, idx;
        prep(len, sg, st);
        @(negedge clk);
        start = 1'b1;
        vec_len = LW'(len);
        sgn = sg;
        sat = st;
        e = cyc + 1;
        if (len == 0) begin
            cur.cyc = e;
            q.push_back(cur);
        end
        @(negedge clk);
        start = 1'b0;
        nb = (len + LANES - 1) / LANES;
        k = 0;
        g = 0;
        while (k < nb && g < 4000) begin
            if (abort_at > 0 && k == abort_at) break;
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int i = 0; i < LANES; i++) begin
                idx = k * LANES + i;
                in_a[i*DW +: DW] = (idx < len) ? ea[idx] : fill;
                in_b[i*DW +: DW] = (idx < len) ? eb[idx] : fill;
            end
            if (in_valid && if48.in_ready) begin
                if (k == nb - 1) begin
                    cur.cyc = cyc + 4;
                    e = cur.cyc;
                    q.push_back(cur);
                end
                k++;
            end
            g++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (abort_at > 0) begin
            chk("abort_beats", 64'(k), 64'(abort_at));
            rstn = 1'b0;
            q.delete();
            #1;
            chk_idle("midrun_reset");
            @(negedge clk);
            rstn = 1'b1;
            repeat (12) @(negedge clk);
            chk_idle("after_abort");
            return;
        end
        chk("beats_fed", 64'(k), 64'(nb));
        if (poke) begin
            g = 0;
            while (cyc < e && g < 100) begin
                @(negedge clk);
                g++;
            end
            start = 1'b1;
            vec_len = '0;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("ignored_start_busy48", 64'(if48.busy), 64'(0));
        end
        g = 0;
        while (q.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'(0));
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ea[i] = 16'(i);
            eb[i] = 16'(i);
        end
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rstn = 1'b1;

        run(256, 0, 0, 0, 16'h0, 0, 0);
        chk("lit_squares48", 64'(got48), 64'd5559680);
        chk("lit_squares32", 64'(got32), 64'd5559680);
        chk("lit_squares_ovf", 64'(gov48), 64'd0);

        run(256, 0, 0, 1, 16'h0, 0, 0);
        chk("lit_gaps48", 64'(got48), 64'd5559680);

        for (int i = 0; i < 4; i++) begin
            ea[i] = 16'hFFFD;
            eb[i] = 16'd5;
        end
        run(4, 1, 0, 0, 16'h0, 0, 1);
        chk("lit_neg48", 64'(got48), 64'h0000_FFFF_FFFF_FFC4);
        chk("lit_neg32", 64'(got32), 64'h0000_0000_FFFF_FFC4);

        for (int i = 0; i < 3; i++) begin
            ea[i] = 16'(i + 1);
            eb[i] = 16'(i + 1);
        end
        run(3, 0, 0, 0, 16'h7FFF, 0, 0);
        chk("lit_mask48", 64'(got48), 64'd14);

        for (int i = 0; i < 3; i++) begin
            ea[i] = 16'h8000;
            eb[i] = 16'h8000;
        end
        run(3, 1, 1, 0, 16'h0, 0, 0);
        chk("lit_sat32", 64'(got32), 64'd2147483647);
        chk("lit_sat_ovf32", 64'(gov32), 64'd1);
        chk("lit_sat48", 64'(got48), 64'd3221225472);
        chk("lit_sat_ovf48", 64'(gov48), 64'd0);

        run(3, 1, 0, 0, 16'h0, 0, 0);
        chk("lit_wrap32", 64'(got32), 64'hC000_0000);
        chk("lit_wrap_ovf32", 64'(gov32), 64'd1);

        run(0, 0, 0, 0, 16'h0, 0, 0);
        chk("lit_zero_res48", 64'(got48), 64'd0);
        chk("lit_zero_err", 64'(gerr), 64'd1);

        for (int i = 0; i < 4; i++) begin
            ea[i] = 16'hFFFF;
            eb[i] = 16'hFFFF;
        end
        run(4, 0, 1, 0, 16'h0, 0, 0);
        chk("lit_usat32", 64'(got32), 64'hFFFF_FFFF);
        chk("lit_usat48", 64'(got48), 64'h3_FFF8_0004);

        for (int i = 0; i < 7; i++) begin
            ea[i] = 16'($urandom);
            eb[i] = 16'($urandom);
        end
        run(7, 1, 0, 1, 16'h1234, 0, 0);

        for (int i = 0; i < 256; i++) begin
            ea[i] = 16'(i);
            eb[i] = 16'(i);
        end
        run(256, 0, 0, 0, 16'h0, 10, 0);

        run(5, 0, 0, 0, 16'h0, 0, 0);
        chk("lit_post_reset48", 64'(got48), 64'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_dot_engine.md
VEC_DOT_ENGINE -- requirements
Module: vec_dot_engine

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, element width in bits.
- LANES, default 2, element pairs accepted per beat (1..8).
- ACC_W, default 48, accumulator/result width (>= 2*DATA_W).
- LEN_W, default 16, vector length counter width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a computation.
- vec_len  in  LEN_W  element count, sampled at accepted start.
- signed_mode  in  1  1 = two's-complement operands, sampled at start.
- sat_mode  in  1  1 = saturate on overflow, 0 = wrap; sampled at start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts beat.
- in_a  in  LANES*DATA_W  vector A elements; lane 0 in the LSBs.
- in_b  in  LANES*DATA_W  vector B elements; lane 0 in the LSBs.
- busy  out  1  computation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse on zero-length start, coincident with done.
- overflow  out  1  sticky accumulator overflow for the current result.
- result  out  ACC_W  dot product, held until the next accepted start.

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-004 start SHALL be accepted only in IDLE and ignored elsewhere.
REQ-005 On an accepted start, the engine SHALL clear the accumulator, result and overflow, and latch vec_len, signed_mode and sat_mode.
REQ-006 An accepted start with vec_len = 0 SHALL move to DONE and pulse error with done; result SHALL be 0.
REQ-007 Otherwise the FSM SHALL enter RUN with beats_left = ceil(vec_len/LANES).
REQ-008 in_ready SHALL be 1 only in RUN; a beat transfers on in_valid & in_ready; beats_left decrements per transfer.
REQ-009 On the final beat, lanes with index >= the remaining element count SHALL be masked to zero.
REQ-010 Pipeline:
- stage 1 registers the LANES products (2*DATA_W, signed or unsigned per mode);
- stage 2 adds the sign- or zero-extended lane sum into the ACC_W accumulator.
REQ-011 The transfer of the final beat SHALL move the FSM RUN -> DRAIN; DRAIN -> DONE once stage 2 has absorbed the last products.
REQ-012 done SHALL pulse exactly 3 cycles after the clock edge that transfers the last beat, and result SHALL be valid in the same cycle.
REQ-013 DONE -> IDLE SHALL occur after one cycle.
REQ-014 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-015 Overflow SHALL be detected per accumulate against the ACC_W range of the current mode.
REQ-016 On overflow, the overflow flag SHALL set and hold until the next accepted start.
REQ-017 On overflow with sat_mode = 1, the accumulator SHALL clamp to the max/min of the mode and stay clamped in the overflow direction.
REQ-018 On overflow with sat_mode = 0, the accumulator SHALL wrap modulo 2^ACC_W.
REQ-019 Input stalls (in_valid = 0) SHALL insert bubbles without corrupting the accumulator or the count.
REQ-020 A start pulse arriving in the DONE cycle SHALL be ignored.

Reset
REQ-021 rstn low SHALL immediately force:
- state IDLE;
- in_ready, busy, done, error and overflow to 0;
- result, accumulator, pipeline registers and counters to 0.
REQ-022 Reset asserted mid-RUN SHALL abandon the computation; no done pulse SHALL follow deassertion.

Structure
REQ-023 Package vec_dot_pkg SHALL hold the FSM state enum and the lane-mask/saturation constant functions.
REQ-024 Sub-module vec_dot_lane_mult SHALL implement one lane multiplier with a mode-selectable signed/unsigned product, instantiated LANES times.

Verification
REQ-025 Unsigned, LANES=2, vec_len=256, a[i]=b[i]=i for i=0..255 -> result=5559680, overflow=0, error=0.
REQ-026 Signed, vec_len=4, a=-3, b=5 -> result=-60 (two's complement in ACC_W).
REQ-027 vec_len=3, LANES=2, a=b={1,2,3}, lane 1 of the final beat driven to 0x7FFF -> result=14, since masking ignores the extra lane.
REQ-028 ACC_W=32, signed, sat_mode=1, vec_len=3, a=b=-32768 -> result=2147483647, overflow=1; with sat_mode=0 -> result=-1073741824, overflow=1.
REQ-029 Zero-length and mid-run reset:
- start with vec_len=0 -> done and error pulse together, result=0;
- rstn pulsed after 10 beats of a 256-element run -> all outputs 0 and no done pulse.
REQ-030 Random in_valid gaps on the REQ-025 stimulus -> identical result, and done exactly 3 cycles after the last transfer.
